// File: rtl/alu_shift_seq.sv
// Sequential 32-bit barrel shifter (SLL/SRL/SRA). A legal request resolves one
// shift-amount bit per clock over five stages; an illegal opcode flags err after one clock.
module alu_shift_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  output logic             ready,
  output logic [WIDTH-1:0] S,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ILL   = 2'd2;

  localparam logic [5:0] OP_SLL = 6'b100000;
  localparam logic [5:0] OP_SRL = 6'b100001;
  localparam logic [5:0] OP_SRA = 6'b100011;

  logic [1:0]       r_state;
  logic [2:0]       r_k;
  logic [4:0]       r_shamt;
  logic             r_left;
  logic             r_sign;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_s;
  logic             r_done;
  logic             r_err;
  logic             r_ready;

  logic             w_legal;
  logic [4:0]       w_sh;
  logic [4:0]       w_amt;
  logic [WIDTH-1:0] w_fill;
  logic [WIDTH-1:0] w_next;
  logic             w_unused;

  assign w_legal  = (ALUFun == OP_SLL) || (ALUFun == OP_SRL) || (ALUFun == OP_SRA);
  assign w_unused = ^A[WIDTH-1:5];

  // Stage k moves the word by 2^k only when shamt bit k is set.
  assign w_sh   = r_shamt >> r_k;
  assign w_amt  = w_sh[0] ? (5'd1 << r_k) : 5'd0;
  // r_sign is the original B[31] for SRA and 0 for SRL, so one path serves both.
  assign w_fill = r_sign ? ~({WIDTH{1'b1}} >> w_amt) : '0;
  assign w_next = r_left ? (r_work << w_amt) : ((r_work >> w_amt) | w_fill);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= 3'd0;
      r_shamt <= 5'd0;
      r_left  <= 1'b0;
      r_sign  <= 1'b0;
      r_work  <= '0;
      r_s     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shamt <= A[4:0];
            r_work  <= B;
            r_left  <= (ALUFun == OP_SLL);
            r_sign  <= (ALUFun == OP_SRA) && B[WIDTH-1];
            r_k     <= 3'd0;
            r_ready <= 1'b0;
            r_state <= w_legal ? SHIFT : ILL;
          end
        end
        SHIFT: begin
          r_work <= w_next;
          r_k    <= r_k + 3'd1;
          if (r_k == 3'd4) begin
            r_s     <= w_next;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        ILL: begin
          r_s     <= '0;
          r_done  <= 1'b1;
          r_err   <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign S     = r_s;
  assign done  = r_done;
  assign err   = r_err;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Scoreboard bench for alu_shift_seq: driver pushes expected results on acceptance,
// a negedge monitor pops and checks value, err and latency on each done pulse.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] A, B;
  logic [5:0]  ALUFun;
  logic        ready;
  logic [31:0] S;
  logic        done, err;

  alu_shift_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .ALUFun(ALUFun),
    .ready(ready), .S(S), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        e;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   last_acc = 0;
  int   last_lat = 0;
  bit   mon_en   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] f);
    int sh;
    sh = a % 32;
    case (f)
      6'b100000: return b << sh;
      6'b100001: return b >> sh;
      6'b100011: return 32'($signed(b) >>> sh);
      default:   return 32'h0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100001) || (f == 6'b100011);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: ready tracks the bench's own busy window; done pops the scoreboard.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("ready", {31'd0, ready}, {31'd0, (cyc >= last_acc + last_lat)});
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t x;
          x = q.pop_front();
          check("S", S, x.s);
          check("err", {31'd0, err}, {31'd0, x.e});
          check("latency", cyc - x.acc, x.lat);
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  // Present operands at negedge while ready; the following posedge accepts.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                       input logic [31:0] exp_s, input bit keep_start);
    exp_t x;
    @(negedge clk);
    wait_ready();
    A = a; B = b; ALUFun = f; start = 1'b1;
    @(posedge clk); #1;
    x.s   = exp_s;
    x.e   = !is_legal(f);
    x.acc = cyc;
    x.lat = is_legal(f) ? 5 : 1;
    q.push_back(x);
    last_acc = cyc;
    last_lat = x.lat;
    if (!keep_start) start = 1'b0;
    // Scramble inputs after acceptance; latched operands must not follow.
    A = $urandom; B = $urandom; ALUFun = 6'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [5:0]  rf;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; ALUFun = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_S", S, 32'h0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    mon_en = 1;

    // Directed vectors with constants derived by hand.
    issue(32'h8, 32'hB38F0F83, 6'b100000, 32'h8F0F8300, 0);
    issue(32'h8, 32'hB38F0F83, 6'b100001, 32'h00B38F0F, 0);
    issue(32'h8, 32'hB38F0F83, 6'b100011, 32'hFFB38F0F, 0);
    issue(32'hFFFFFFF7, 32'h4C70F07C, 6'b100000, 32'h3E000000, 0);
    issue(32'hFFFFFFF7, 32'h4C70F07C, 6'b100011, 32'h00000098, 0);
    issue(32'h0, 32'h12345678, 6'b100001, 32'h12345678, 0);
    issue(32'd31, 32'h80000000, 6'b100011, 32'hFFFFFFFF, 0);
    issue(32'h5, 32'hDEADBEEF, 6'b000000, 32'h0, 0);
    drain();

    // Start pulsed while busy must be ignored.
    issue(32'd3, 32'hF0000001, 6'b100001, 32'h1E000000, 0);
    @(negedge clk); start = 1'b1; A = 32'd1; B = 32'h1; ALUFun = 6'b100000;
    @(negedge clk); start = 1'b0;
    drain();

    // Start held high: each done cycle must accept the next request.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      rf = (i == 2) ? 6'b010101 : ((i % 2) ? 6'b100011 : 6'b100000);
      issue(ra, rb, rf, ref_shift(ra, rb, rf), 1);
    end
    start = 1'b0;
    drain();

    // Reset two edges into a shift aborts it.
    issue(32'd4, 32'hCAFEF00D, 6'b100000, 32'hAFEF00D0, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; ALUFun = 6'b100000;
    @(posedge clk); #1;
    q.delete();
    last_lat = 0;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_S", S, 32'h0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    repeat (7) @(negedge clk);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 3))
        0: rf = 6'b100000;
        1: rf = 6'b100001;
        2: rf = 6'b100011;
        default: rf = 6'($urandom);
      endcase
      issue(ra, rb, rf, ref_shift(ra, rb, rf), 0);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
